// File: rtl/tag_ras_unit.sv
// ID-stage target generator: registered branch/call targets plus a circular
// return-address stack that predicts return targets without a register read.
module tag_ras_unit #(
  parameter int ADDR_W     = 32,
  parameter int RAS_DEPTH  = 8,
  parameter int RET_OFFSET = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           STALL_ID,
  input  logic                           FLUSH,
  input  logic [ADDR_W-1:0]              PC_ID,
  input  logic [21:0]                    DISP22,
  input  logic [29:0]                    DISP30,
  input  logic                           CALL_ID,
  input  logic                           RET_ID,
  input  logic                           BI_ID,
  output logic [ADDR_W-1:0]              TAG_OUT,
  output logic                           TAG_VALID,
  output logic [1:0]                     TAG_SRC,
  output logic                           RET_MISS,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RAS_COUNT,
  output logic                           RAS_OVF
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_CALL = 2'b10;
  localparam logic [1:0] SRC_RET  = 2'b11;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  // top points at the next free slot; when full it is also the oldest entry,
  // so an overflowing push naturally overwrites the oldest return address.
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  pop_idx;
  logic [31:0]       call_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] call_tgt;
  logic [ADDR_W-1:0] ret_addr;
  logic              push_en;
  logic              ras_full;
  logic              ras_empty;

  assign call_off  = {DISP30, 2'b00};
  assign br_tgt    = PC_ID + ({{(ADDR_W-22){DISP22[21]}}, DISP22} << 2);
  assign call_tgt  = PC_ID + call_off[ADDR_W-1:0];
  assign ret_addr  = PC_ID + ADDR_W'(RET_OFFSET);
  assign pop_idx   = top - 1'b1;
  assign ras_full  = (RAS_COUNT == CNT_W'(RAS_DEPTH));
  assign ras_empty = (RAS_COUNT == '0);
  assign push_en   = !reset && !STALL_ID && !FLUSH && CALL_ID;

  always_ff @(posedge clk) begin
    if (push_en) ras_mem[top] <= ret_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      TAG_OUT   <= '0;
      TAG_VALID <= 1'b0;
      TAG_SRC   <= SRC_NONE;
      RET_MISS  <= 1'b0;
      RAS_COUNT <= '0;
      RAS_OVF   <= 1'b0;
      top       <= '0;
    end else if (STALL_ID) begin
      RET_MISS <= 1'b0;
    end else begin
      RET_MISS <= 1'b0;
      if (FLUSH) begin
        TAG_OUT   <= '0;
        TAG_VALID <= 1'b0;
        TAG_SRC   <= SRC_NONE;
      end else if (CALL_ID) begin
        TAG_OUT   <= call_tgt;
        TAG_VALID <= 1'b1;
        TAG_SRC   <= SRC_CALL;
        top       <= top + 1'b1;
        if (ras_full) RAS_OVF   <= 1'b1;
        else          RAS_COUNT <= RAS_COUNT + 1'b1;
      end else if (RET_ID) begin
        if (!ras_empty) begin
          TAG_OUT   <= ras_mem[pop_idx];
          TAG_VALID <= 1'b1;
          TAG_SRC   <= SRC_RET;
          top       <= pop_idx;
          RAS_COUNT <= RAS_COUNT - 1'b1;
        end else begin
          TAG_OUT   <= '0;
          TAG_VALID <= 1'b0;
          TAG_SRC   <= SRC_NONE;
          RET_MISS  <= 1'b1;
        end
      end else if (BI_ID) begin
        TAG_OUT   <= br_tgt;
        TAG_VALID <= 1'b1;
        TAG_SRC   <= SRC_BR;
      end else begin
        TAG_OUT   <= '0;
        TAG_VALID <= 1'b0;
        TAG_SRC   <= SRC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_tag_ras_unit.sv
// Directed bench for tag_ras_unit: hand-computed targets, RAS push/pop order,
// overflow, stall freeze, flush and reset behaviour.
module tb_tag_ras_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        STALL_ID, FLUSH;
  logic [31:0] PC_ID;
  logic [21:0] DISP22;
  logic [29:0] DISP30;
  logic        CALL_ID, RET_ID, BI_ID;
  logic [31:0] TAG_OUT;
  logic        TAG_VALID;
  logic [1:0]  TAG_SRC;
  logic        RET_MISS;
  logic [3:0]  RAS_COUNT;
  logic        RAS_OVF;

  int n_tests = 0;
  int n_fail  = 0;

  tag_ras_unit #(.ADDR_W(32), .RAS_DEPTH(8), .RET_OFFSET(8)) dut (
    .clk(clk), .reset(reset), .STALL_ID(STALL_ID), .FLUSH(FLUSH),
    .PC_ID(PC_ID), .DISP22(DISP22), .DISP30(DISP30),
    .CALL_ID(CALL_ID), .RET_ID(RET_ID), .BI_ID(BI_ID),
    .TAG_OUT(TAG_OUT), .TAG_VALID(TAG_VALID), .TAG_SRC(TAG_SRC),
    .RET_MISS(RET_MISS), .RAS_COUNT(RAS_COUNT), .RAS_OVF(RAS_OVF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Outputs are checked 1 time unit after the edge, clear of the update.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic c, input logic r, input logic b,
                     input logic [31:0] pc, input logic [21:0] d22, input logic [29:0] d30);
    CALL_ID = c; RET_ID = r; BI_ID = b;
    PC_ID = pc; DISP22 = d22; DISP30 = d30;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] out, input logic v,
                         input logic [1:0] src, input logic [3:0] cnt);
    chk({tag, "_out"},   TAG_OUT,   out);
    chk({tag, "_valid"}, {31'd0, TAG_VALID}, {31'd0, v});
    chk({tag, "_src"},   {30'd0, TAG_SRC},   {30'd0, src});
    chk({tag, "_count"}, {28'd0, RAS_COUNT}, {28'd0, cnt});
  endtask

  initial begin
    reset = 1'b1; STALL_ID = 1'b0; FLUSH = 1'b0;
    req(1'b0, 1'b0, 1'b0, 32'h0, 22'h0, 30'h0);
    cyc(); cyc();
    chk_out("reset", 32'h0, 1'b0, 2'b00, 4'd0);
    chk("reset_miss", {31'd0, RET_MISS}, 32'd0);
    chk("reset_ovf",  {31'd0, RAS_OVF},  32'd0);

    reset = 1'b0;
    req(1'b0, 1'b0, 1'b1, 32'h0000_1000, 22'h3FFFFC, 30'h0);
    cyc();
    chk_out("branch_neg", 32'h0000_0FF0, 1'b1, 2'b01, 4'd0);

    // CALL + BI together: call wins
    req(1'b1, 1'b0, 1'b1, 32'h0000_2000, 22'h000001, 30'h100);
    cyc();
    chk_out("call", 32'h0000_2400, 1'b1, 2'b10, 4'd1);
    req(1'b0, 1'b1, 1'b1, 32'h0000_7777, 22'h000001, 30'h0);
    cyc();
    chk_out("ret", 32'h0000_2008, 1'b1, 2'b11, 4'd0);

    req(1'b0, 1'b1, 1'b0, 32'h0000_3000, 22'h0, 30'h0);
    cyc();
    chk_out("ret_empty", 32'h0, 1'b0, 2'b00, 4'd0);
    chk("ret_empty_miss", {31'd0, RET_MISS}, 32'd1);
    req(1'b0, 1'b0, 1'b0, 32'h0, 22'h0, 30'h0);
    cyc();
    chk("miss_pulse_end", {31'd0, RET_MISS}, 32'd0);
    chk_out("idle", 32'h0, 1'b0, 2'b00, 4'd0);

    for (int i = 1; i <= 9; i++) begin
      req(1'b1, 1'b0, 1'b0, 32'(i) << 8, 22'h0, 30'h0);
      cyc();
      chk_out($sformatf("ovf_call%0d", i), 32'(i) << 8, 1'b1, 2'b10, (i > 8) ? 4'd8 : 4'(i));
      chk($sformatf("ovf_flag%0d", i), {31'd0, RAS_OVF}, (i > 8) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      req(1'b0, 1'b1, 1'b0, 32'h0, 22'h0, 30'h0);
      cyc();
      chk_out($sformatf("ovf_ret%0d", k), 32'h0000_0908 - (32'(k) << 8), 1'b1, 2'b11, 4'(7 - k));
    end
    req(1'b0, 1'b1, 1'b0, 32'h0, 22'h0, 30'h0);
    cyc();
    chk("ovf_ret9_miss", {31'd0, RET_MISS}, 32'd1);
    chk_out("ovf_ret9", 32'h0, 1'b0, 2'b00, 4'd0);
    chk("ovf_sticky", {31'd0, RAS_OVF}, 32'd1);

    // Stall immediately after a miss: miss pulse is forced low
    STALL_ID = 1'b1;
    cyc();
    chk("stall_miss_low", {31'd0, RET_MISS}, 32'd0);
    STALL_ID = 1'b0;

    req(1'b0, 1'b0, 1'b1, 32'h0000_3000, 22'h000001, 30'h0);
    cyc();
    chk_out("pre_stall_br", 32'h0000_3004, 1'b1, 2'b01, 4'd0);
    STALL_ID = 1'b1;
    req(1'b1, 1'b1, 1'b0, 32'h0000_4000, 22'h0, 30'h10);
    cyc();
    chk_out("stall1", 32'h0000_3004, 1'b1, 2'b01, 4'd0);
    cyc();
    chk_out("stall2", 32'h0000_3004, 1'b1, 2'b01, 4'd0);
    chk("stall2_miss", {31'd0, RET_MISS}, 32'd0);
    STALL_ID = 1'b0;
    cyc();
    chk_out("stall_release", 32'h0000_4040, 1'b1, 2'b10, 4'd1);
    chk("stall_release_miss", {31'd0, RET_MISS}, 32'd0);

    FLUSH = 1'b1;
    req(1'b1, 1'b0, 1'b0, 32'h0000_5000, 22'h0, 30'h10);
    cyc();
    chk_out("flush", 32'h0, 1'b0, 2'b00, 4'd1);
    FLUSH = 1'b0;
    req(1'b0, 1'b1, 1'b0, 32'h0, 22'h0, 30'h0);
    cyc();
    chk_out("post_flush_ret", 32'h0000_4008, 1'b1, 2'b11, 4'd0);

    req(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 22'h000008, 30'h0);
    cyc();
    chk_out("wrap", 32'h0000_0010, 1'b1, 2'b01, 4'd0);

    req(1'b1, 1'b0, 1'b0, 32'h0000_6000, 22'h0, 30'h0);
    cyc();
    chk_out("pre_reset_call", 32'h0000_6000, 1'b1, 2'b10, 4'd1);
    reset = 1'b1;
    req(1'b0, 1'b1, 1'b0, 32'h0, 22'h0, 30'h0);
    cyc();
    chk_out("mid_reset", 32'h0, 1'b0, 2'b00, 4'd0);
    chk("mid_reset_ovf", {31'd0, RAS_OVF}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("after_reset_miss", {31'd0, RET_MISS}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_ras_unit.md
Name: tag_ras_unit

Overview:
- Registered, parametrised target address generator for the ID stage.
- Computes CALL targets (PC + disp30<<2) and BRANCH targets (PC + sext(disp22)<<2).
- Adds a circular return-address stack (RAS), so a return instruction gets a predicted target with no register-file read.
- Sits between ID decode and IF PC-select; its output is one cycle after the ID inputs.

Parameters:
- ADDR_W, 32: PC/target width; all address arithmetic is modulo 2^ADDR_W; legal range 24..32.
- RAS_DEPTH, 8: number of RAS entries; power of two, 2..32.
- RET_OFFSET, 8: added to PC_ID to form the pushed return address (SPARC call + delay slot).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- STALL_ID  in  1  ID stage held; freezes all state.
- FLUSH  in  1  kills the pending target; RAS is untouched.
- PC_ID  in  ADDR_W  PC of the instruction in ID.
- DISP22  in  22  branch displacement, signed, word units.
- DISP30  in  30  call displacement, word units.
- CALL_ID  in  1  CALL in ID.
- RET_ID  in  1  return (jmpl %o7+8 / %i7+8) in ID.
- BI_ID  in  1  branch taken in ID.
- TAG_OUT  out  ADDR_W  registered target address.
- TAG_VALID  out  1  TAG_OUT is a valid redirect this cycle.
- TAG_SRC  out  2  source of the target: 00 none, 01 branch, 10 call, 11 return.
- RET_MISS  out  1  one-cycle pulse: return seen while the RAS was empty.
- RAS_COUNT  out  $clog2(RAS_DEPTH+1)  number of valid entries.
- RAS_OVF  out  1  sticky flag: a push overwrote an entry.

Behaviour:
Reset:
- On the first rising edge with reset=1: TAG_OUT=0, TAG_VALID=0, TAG_SRC=00, RET_MISS=0, RAS_COUNT=0, RAS_OVF=0, top pointer=0.
- RAS contents become don't-care.
- Reset mid-operation discards every pending push, pop and target.

Arithmetic:
- Branch target = PC_ID + (sign-extend DISP22 to ADDR_W) << 2.
- Call target = PC_ID + ({DISP30,2'b00} truncated to ADDR_W).
- Return address = PC_ID + RET_OFFSET.
- Every sum wraps modulo 2^ADDR_W. No overflow detection.

Cycle behaviour when STALL_ID=0, reset=0: one decision is registered per edge, in fixed priority CALL > RET > BI.
- CALL_ID=1:
  - TAG_OUT=call target, TAG_SRC=10, TAG_VALID=1.
  - Push the return address.
  - If RAS_COUNT==RAS_DEPTH: overwrite the oldest entry (circular), RAS_COUNT stays at RAS_DEPTH, RAS_OVF<=1.
- RET_ID=1 (and CALL_ID=0):
  - If RAS_COUNT>0: TAG_OUT=top entry, pop, TAG_SRC=11, TAG_VALID=1.
  - If RAS_COUNT==0: TAG_VALID=0, TAG_SRC=00, TAG_OUT=0, RET_MISS=1 for one cycle, no pointer change.
- BI_ID=1 (and CALL_ID=0, RET_ID=0): TAG_OUT=branch target, TAG_SRC=01, TAG_VALID=1. RAS unchanged.
- No request: TAG_OUT=0, TAG_VALID=0, TAG_SRC=00.
- Simultaneous CALL and RET: CALL wins; RET is dropped with no pop and no RET_MISS.
- Simultaneous CALL and BI, or RET and BI: the higher-priority event wins; BI is dropped.

Stall and flush:
- STALL_ID=1: all registers hold, including TAG_VALID. RET_MISS is forced to 0. No push or pop.
- STALL_ID dominates FLUSH.
- FLUSH=1 (STALL_ID=0):
  - TAG_VALID<=0, TAG_SRC<=00, TAG_OUT<=0.
  - Request inputs are ignored for that edge.
  - No push or pop occurs; RAS_COUNT and pointer hold.

Pointers:
- The top pointer wraps modulo RAS_DEPTH.
- Pop after an overflow returns the most recent entries. Once the count reaches 0, the overwritten entries are lost and further returns produce RET_MISS.

Latency: 1 cycle from inputs sampled at an edge to outputs valid after that edge.

Test Plan:
- Reset, then BI_ID=1, PC_ID=0x0000_1000, DISP22=0x3FFFFC (-4) -> TAG_OUT=0x0000_0FF0, TAG_SRC=01, TAG_VALID=1, RAS_COUNT=0.
- CALL_ID=1, PC_ID=0x0000_2000, DISP30=0x100; next cycle RET_ID=1 -> first output 0x0000_2400 with TAG_SRC=10 and RAS_COUNT=1; second output 0x0000_2008 with TAG_SRC=11 and RAS_COUNT=0.
- RET_ID=1 with an empty RAS -> TAG_VALID=0, RET_MISS high for exactly one cycle, RAS_COUNT=0.
- RAS_DEPTH+1 calls at PC 0x100, 0x200, ... -> RAS_OVF=1, RAS_COUNT=8. The following 8 returns yield 0x908 down to 0x208. The 9th return gives RET_MISS.
- CALL_ID=1 and RET_ID=1 together, with STALL_ID=1 for 2 cycles before release -> outputs frozen during the stall; after release only the call takes effect (push, TAG_SRC=10).
- FLUSH=1 with CALL_ID=1 -> TAG_VALID=0, RAS_COUNT unchanged. Wrap check: PC_ID=0xFFFF_FFF0, DISP22=8 -> TAG_OUT=0x0000_0010.
